// File: rtl/pw_layer_sequencer.sv
// Pointwise 1x1 layer sequencer: drives the conv engine one output channel at a time.
// Optional build macro PW_SEQ_RELU_EN clamps negative results to zero.
module pw_layer_sequencer #(
    parameter int NUM_MACS = 16,
    parameter int TIMEOUT  = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [9:0]            cfg_in_ch,
    input  logic [9:0]            cfg_out_ch,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  wt_rd_en,
    output logic [15:0]           wt_rd_addr,
    input  logic [8*NUM_MACS-1:0] wt_rd_data,
    output logic                  act_rd_en,
    output logic [5:0]            act_rd_addr,
    input  logic [8*NUM_MACS-1:0] act_rd_data,
    output logic [9:0]            eng_num_in_ch,
    output logic [9:0]            eng_num_out_ch,
    output logic [8*NUM_MACS-1:0] eng_act,
    output logic [8*NUM_MACS-1:0] eng_wt,
    output logic                  eng_start,
    output logic                  eng_clear,
    output logic                  eng_load,
    input  logic [31:0]           eng_result,
    input  logic                  eng_result_valid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic [9:0]            out_ch
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_OC_START,
        S_FETCH,
        S_LOAD,
        S_GAP1,
        S_GAP2,
        S_WAIT_RES,
        S_EMIT,
        S_FIN
    } state_t;

    state_t          state;
    logic [9:0]      in_ch;
    logic [9:0]      out_n;
    logic [15:0]     nb;
    logic [5:0]      nb_m1;
    logic [5:0]      b;
    logic [9:0]      oc;
    logic [15:0]     base;
    logic [TW-1:0]   tmr;
    logic [10:0]     nb_calc;
    logic [16:0]     lane_base;
    logic [31:0]     res_q;

    assign eng_num_out_ch = 10'd1;
    assign nb_calc = ({1'b0, cfg_in_ch} + 11'(NUM_MACS - 1)) / 11'(NUM_MACS);

    // Lanes past the last input channel are zeroed; only the last batch can hit this.
    always_comb begin
        eng_wt    = '0;
        eng_act   = '0;
        lane_base = 17'(b) * 17'(NUM_MACS);
        if (state == S_LOAD) begin
            for (int i = 0; i < NUM_MACS; i++) begin
                if ((lane_base + 17'(i)) < {7'd0, in_ch}) begin
                    eng_wt[8*i +: 8]  = wt_rd_data[8*i +: 8];
                    eng_act[8*i +: 8] = act_rd_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
`ifdef PW_SEQ_RELU_EN
        res_q = eng_result[31] ? 32'd0 : eng_result;
`else
        res_q = eng_result;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            in_ch         <= '0;
            out_n         <= '0;
            nb            <= '0;
            nb_m1         <= '0;
            b             <= '0;
            oc            <= '0;
            base          <= '0;
            tmr           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            wt_rd_en      <= 1'b0;
            wt_rd_addr    <= '0;
            act_rd_en     <= 1'b0;
            act_rd_addr   <= '0;
            eng_num_in_ch <= '0;
            eng_start     <= 1'b0;
            eng_clear     <= 1'b0;
            eng_load      <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_ch        <= '0;
        end else begin
            done      <= 1'b0;
            eng_start <= 1'b0;
            eng_clear <= 1'b0;
            eng_load  <= 1'b0;
            wt_rd_en  <= 1'b0;
            act_rd_en <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (cfg_in_ch == 10'd0 || cfg_out_ch == 10'd0) begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end else begin
                            in_ch         <= cfg_in_ch;
                            eng_num_in_ch <= cfg_in_ch;
                            out_n         <= cfg_out_ch;
                            nb            <= 16'(nb_calc);
                            nb_m1         <= 6'(nb_calc - 11'd1);
                            oc            <= '0;
                            base          <= '0;
                            b             <= '0;
                            busy          <= 1'b1;
                            eng_start     <= 1'b1;
                            eng_clear     <= 1'b1;
                            state         <= S_OC_START;
                        end
                    end
                end
                S_OC_START: begin
                    b           <= '0;
                    wt_rd_en    <= 1'b1;
                    act_rd_en   <= 1'b1;
                    wt_rd_addr  <= base;
                    act_rd_addr <= '0;
                    state       <= S_FETCH;
                end
                S_FETCH: begin
                    eng_load <= 1'b1;
                    state    <= S_LOAD;
                end
                S_LOAD: state <= S_GAP1;
                S_GAP1: state <= S_GAP2;
                S_GAP2: begin
                    if (b != nb_m1) begin
                        b           <= b + 6'd1;
                        wt_rd_en    <= 1'b1;
                        act_rd_en   <= 1'b1;
                        wt_rd_addr  <= base + 16'(b) + 16'd1;
                        act_rd_addr <= b + 6'd1;
                        state       <= S_FETCH;
                    end else begin
                        tmr   <= '0;
                        state <= S_WAIT_RES;
                    end
                end
                S_WAIT_RES: begin
                    if (eng_result_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= res_q;
                        out_ch    <= oc;
                        state     <= S_EMIT;
                    end else if (tmr == TW'(TIMEOUT - 1)) begin
                        err       <= 1'b1;
                        eng_clear <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_FIN;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (oc == out_n - 10'd1) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_FIN;
                        end else begin
                            oc        <= oc + 10'd1;
                            base      <= base + nb;
                            eng_start <= 1'b1;
                            eng_clear <= 1'b1;
                            state     <= S_OC_START;
                        end
                    end
                end
                S_FIN: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pw_layer_sequencer.sv
// Scoreboard bench for pw_layer_sequencer with RAM and engine models.
module tb_pw_layer_sequencer;

    localparam int NM  = 16;
    localparam int TMO = 16;
    localparam int W   = 8 * NM;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [9:0]    cfg_in_ch = '0;
    logic [9:0]    cfg_out_ch = '0;
    logic          busy, done, err;
    logic          wt_rd_en, act_rd_en;
    logic [15:0]   wt_rd_addr;
    logic [5:0]    act_rd_addr;
    logic [W-1:0]  wt_rd_data = '0;
    logic [W-1:0]  act_rd_data = '0;
    logic [9:0]    eng_num_in_ch, eng_num_out_ch;
    logic [W-1:0]  eng_act, eng_wt;
    logic          eng_start, eng_clear, eng_load;
    logic [31:0]   eng_result = '0;
    logic          eng_result_valid = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_data;
    logic [9:0]    out_ch;

    pw_layer_sequencer #(.NUM_MACS(NM), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .start(start),
        .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch),
        .busy(busy), .done(done), .err(err),
        .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .wt_rd_data(wt_rd_data),
        .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
        .eng_num_in_ch(eng_num_in_ch), .eng_num_out_ch(eng_num_out_ch),
        .eng_act(eng_act), .eng_wt(eng_wt),
        .eng_start(eng_start), .eng_clear(eng_clear), .eng_load(eng_load),
        .eng_result(eng_result), .eng_result_valid(eng_result_valid),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [W-1:0] wt_mem [64];
    logic [W-1:0] act_mem[64];

    always @(posedge clock) begin
        if (wt_rd_en)  wt_rd_data  <= wt_mem[wt_rd_addr[5:0]];
        if (act_rd_en) act_rd_data <= act_mem[act_rd_addr];
    end

    function automatic int dot(input logic [W-1:0] w, input logic [W-1:0] a);
        int s;
        s = 0;
        for (int i = 0; i < NM; i++)
            s += int'($signed(w[8*i +: 8])) * int'($signed(a[8*i +: 8]));
        return s;
    endfunction

    // engine model: accumulate loads, fire result a few cycles after the last one
    bit suppress = 1'b0;
    int acc = 0, nld = 0, cd = 0;
    always @(posedge clock) begin
        eng_result_valid <= 1'b0;
        if (reset || eng_clear) begin
            acc <= 0; nld <= 0; cd <= 0;
        end else if (eng_load) begin
            acc <= acc + dot(eng_wt, eng_act);
            nld <= nld + 1;
            if (nld + 1 == (int'(eng_num_in_ch) + NM - 1) / NM) cd <= 3;
        end else if (cd != 0) begin
            cd <= cd - 1;
            if (cd == 1 && !suppress) begin
                eng_result_valid <= 1'b1;
                eng_result <= acc;
            end
        end
    end

    function automatic logic [31:0] model(input int inc, input int oc);
        int nb, s;
        byte w, a;
        nb = (inc + NM - 1) / NM;
        s = 0;
        for (int i = 0; i < inc; i++) begin
            w = wt_mem[oc*nb + i/NM][8*(i%NM) +: 8];
            a = act_mem[i/NM][8*(i%NM) +: 8];
            s += int'(w) * int'(a);
        end
`ifdef PW_SEQ_RELU_EN
        if (s < 0) s = 0;
`endif
        return 32'(s);
    endfunction

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int           ld_cyc[$];
    logic [W-1:0] ld_wt[$];
    int           addr_q[$];
    logic [41:0]  sbq[$];
    logic [41:0]  exp_e;
    logic [31:0]  last_data = '0;
    int dn_cnt = 0, clr_cnt = 0, st_cnt = 0, ov_cnt = 0, busy_cnt = 0;
    int err_cyc = -1;
    bit prev_err = 1'b0;

    always @(negedge clock) begin
        if (eng_load) begin
            ld_cyc.push_back(cyc);
            ld_wt.push_back(eng_wt);
        end
        if (wt_rd_en)  addr_q.push_back(int'(wt_rd_addr));
        if (done)      dn_cnt++;
        if (eng_clear) clr_cnt++;
        if (eng_start) st_cnt++;
        if (out_valid) ov_cnt++;
        if (busy)      busy_cnt++;
        if (err && !prev_err) err_cyc = cyc;
        prev_err = err;
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_extra", 1, 0);
            end else begin
                exp_e = sbq.pop_front();
                chk("sb_out", {out_ch, out_data}, exp_e);
                last_data = out_data;
            end
        end
    end

    int rdy_mode = 0;
    initial forever begin
        @(posedge clock);
        #1;
        out_ready = (rdy_mode == 0) ? 1'b1 :
                    (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    initial begin
        #300000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic fill(input logic [7:0] w, input logic [7:0] a);
        for (int i = 0; i < 64; i++) begin
            wt_mem[i]  = {NM{w}};
            act_mem[i] = {NM{a}};
        end
    endtask

    task automatic do_start(input int inc, input int outc);
        @(posedge clock);
        #1;
        start = 1'b1;
        cfg_in_ch = 10'(inc);
        cfg_out_ch = 10'(outc);
        if (inc != 0 && outc != 0 && !suppress)
            for (int o = 0; o < outc; o++)
                sbq.push_back({10'(o), model(inc, o)});
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        @(negedge clock);
        while (!done && n < budget) begin
            @(negedge clock);
            n++;
        end
        chk("done_seen", done, 1);
        @(negedge clock);
    endtask

    int b0, a0, d0, s0, c0, o0, u0, n;
    logic [W-1:0] tail;
    logic [31:0]  expn;

    initial begin
        fill(8'h00, 8'h00);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_nout", eng_num_out_ch, 1);
        chk("rst_ov", out_valid, 0);
        chk("rst_ctl", {wt_rd_en, act_rd_en, eng_load, eng_start, eng_clear}, 0);

        // 96 channels, one output channel
        fill(8'h01, 8'h01);
        b0 = ld_cyc.size(); a0 = addr_q.size(); d0 = dn_cnt;
        do_start(96, 1);
        wait_done(300);
        chk("t1_nld", ld_cyc.size() - b0, 6);
        for (int k = 1; k < 6; k++)
            chk("t1_gap", ld_cyc[b0+k] - ld_cyc[b0+k-1], 4);
        for (int k = 0; k < 6; k++)
            chk("t1_addr", addr_q[a0+k], k);
        chk("t1_res", last_data, 96);
        chk("t1_done", dn_cnt - d0, 1);
        chk("t1_sb", sbq.size(), 0);

        // 20 channels, two output channels: tail masking
        b0 = ld_cyc.size(); a0 = addr_q.size();
        do_start(20, 2);
        wait_done(400);
        chk("t2_nld", ld_cyc.size() - b0, 4);
        chk("t2_full", ld_wt[b0], {NM{8'h01}});
        tail = '0;
        tail[31:0] = 32'h01010101;
        chk("t2_tail", ld_wt[b0+1], tail);
        for (int k = 0; k < 4; k++)
            chk("t2_addr", addr_q[a0+k], k);
        chk("t2_res", last_data, 20);
        chk("t2_sb", sbq.size(), 0);

        // output stall
        rdy_mode = 1;
        s0 = st_cnt;
        do_start(16, 2);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("t3_ov", out_valid, 1);
        repeat (5) begin
            @(negedge clock);
            chk("t3_hold", {out_valid, out_ch, out_data}, {1'b1, 10'd0, 32'd16});
        end
        chk("t3_nstart", st_cnt - s0, 1);
        rdy_mode = 0;
        wait_done(300);
        chk("t3_nstart2", st_cnt - s0, 2);
        chk("t3_sb", sbq.size(), 0);

        // start while busy is ignored
        b0 = ld_cyc.size(); a0 = addr_q.size(); d0 = dn_cnt;
        do_start(32, 1);
        repeat (3) @(posedge clock);
        #1;
        start = 1'b1;
        cfg_in_ch = 10'd96;
        cfg_out_ch = 10'd3;
        @(posedge clock);
        #1 start = 1'b0;
        wait_done(300);
        repeat (20) @(negedge clock);
        chk("t4_nld", ld_cyc.size() - b0, 2);
        chk("t4_naddr", addr_q.size() - a0, 2);
        chk("t4_addr1", addr_q[a0+1], 1);
        chk("t4_done", dn_cnt - d0, 1);
        chk("t4_res", last_data, 32);
        chk("t4_sb", sbq.size(), 0);

        // zero output channels
        a0 = addr_q.size(); u0 = busy_cnt; b0 = ld_cyc.size();
        do_start(8, 0);
        @(negedge clock);
        chk("z_done", done, 1);
        chk("z_busy", busy, 0);
        @(negedge clock);
        chk("z_done2", done, 0);
        chk("z_busycnt", busy_cnt - u0, 0);
        chk("z_rd", (addr_q.size() - a0) + (ld_cyc.size() - b0), 0);

        // timeout
        suppress = 1'b1;
        c0 = clr_cnt; o0 = ov_cnt; d0 = dn_cnt;
        do_start(16, 1);
        wait_done(200);
        repeat (10) @(negedge clock);
        chk("t5_err", err, 1);
        chk("t5_clr", clr_cnt - c0, 2);
        chk("t5_ov", ov_cnt - o0, 0);
        chk("t5_done", dn_cnt - d0, 1);
        chk("t5_when", err_cyc - ld_cyc[ld_cyc.size()-1], 3 + TMO);
        suppress = 1'b0;

        // reset in the middle of channel 0
        fill(8'h01, 8'h01);
        b0 = ld_cyc.size();
        do_start(96, 1);
        n = 0;
        while (ld_cyc.size() - b0 < 3 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("t6_ld3", (ld_cyc.size() - b0) >= 3, 1);
        d0 = dn_cnt;
        @(posedge clock);
        #1 reset = 1'b1;
        sbq.delete();
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("t6_ctl", {busy, done, err, wt_rd_en, act_rd_en, eng_load, eng_start,
                       eng_clear, out_valid, wt_rd_addr, act_rd_addr, out_ch,
                       eng_num_in_ch}, 0);
        chk("t6_dat", out_data, 0);
        chk("t6_eng", eng_wt | eng_act, 0);
        chk("t6_nout", eng_num_out_ch, 1);
        repeat (5) @(negedge clock);
        chk("t6_nodone", dn_cnt - d0, 0);
        do_start(16, 1);
        wait_done(200);
        chk("t6_err", err, 0);
        chk("t6_res", last_data, 16);
        chk("t6_sb", sbq.size(), 0);

        // negative weights
        fill(8'hFF, 8'h01);
        do_start(40, 1);
        wait_done(300);
`ifdef PW_SEQ_RELU_EN
        expn = 32'd0;
`else
        expn = -32'sd40;
`endif
        chk("t7_neg", last_data, expn);
        chk("t7_sb", sbq.size(), 0);

        // random data, random backpressure
        for (int i = 0; i < 64; i++) begin
            wt_mem[i]  = {$urandom, $urandom, $urandom, $urandom};
            act_mem[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        rdy_mode = 2;
        do_start(37, 3);
        wait_done(1000);
        rdy_mode = 0;
        chk("t8_sb", sbq.size(), 0);
        chk("t8_err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pw_layer_sequencer.md
# pw_layer_sequencer

Controller that runs a full 1x1 pointwise convolution layer on the `pointwise_conv1x1_engine`, one output channel at a time. For each output channel it fetches weight and activation batches of NUM_MACS lanes from external synchronous RAMs. It masks lanes past the last input channel and drives the engine's start/load handshake. It then collects each `conv_result` into a valid/ready output stream tagged with its output-channel index.

## Interface

Parameters:
- NUM_MACS, 16, lanes per batch; must match the engine.
- TIMEOUT, 256, maximum cycles to wait for `eng_result_valid` before aborting.

Ports:
- clock  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; latches cfg_* and begins a layer.
- cfg_in_ch  in  10  number of input channels.
- cfg_out_ch  in  10  number of output channels.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at layer end.
- err  out  1  sticky timeout flag; cleared by the next accepted start.
- wt_rd_en  out  1  weight RAM read strobe.
- wt_rd_addr  out  16  weight word address, computed as oc*nb + b.
- wt_rd_data  in  8*NUM_MACS  returned weight word; lane i is bits [8i+7:8i]; 1-cycle read latency.
- act_rd_en  out  1  activation RAM read strobe.
- act_rd_addr  out  6  batch index b.
- act_rd_data  in  8*NUM_MACS  returned activation word; 1-cycle read latency.
- eng_num_in_ch  out  10  latched cfg_in_ch.
- eng_num_out_ch  out  10  constant 1.
- eng_act, eng_wt  out  8*NUM_MACS  masked lane data for the engine.
- eng_start, eng_clear, eng_load  out  1  engine control pulses.
- eng_result  in  32  signed engine result.
- eng_result_valid  in  1  engine result strobe.
- out_valid  out  1  output stream valid.
- out_ready  in  1  output stream ready.
- out_data  out  32  result for one output channel.
- out_ch  out  10  output-channel index of out_data.

## Operation

- nb = ceil(cfg_in_ch / NUM_MACS), computed once at start. Counters: oc (0..cfg_out_ch-1) and b (0..nb-1).
- States and transitions:
  - IDLE: go to OC_START on an accepted start.
  - OC_START: eng_start=1 and eng_clear=1 for one cycle, b=0, then FETCH.
  - FETCH: wt_rd_en=act_rd_en=1 at the current addresses, then LOAD.
  - LOAD: eng_load=1, eng_wt/eng_act = RAM data with masking applied, then GAP1.
  - GAP1, GAP2: idle cycles. After GAP2, go to FETCH with b+1 if b<nb-1, otherwise WAIT_RES.
  - WAIT_RES: capture eng_result on eng_result_valid and go to EMIT.
  - EMIT: hold out_valid until out_ready. On the handshake, go to OC_START with oc+1, or to FIN after the last oc.
  - FIN: done=1, then IDLE.
- Masking: in the last batch, lane i is forced to 0x00 in both eng_wt and eng_act when b*NUM_MACS+i >= cfg_in_ch.
- Weight RAM layout: per output channel, nb consecutive words; the tail lanes of the last word are don't-care.
- out_data = eng_result passed through unchanged (signed 32-bit); out_ch = oc.
- Start handling:
  - start while busy is ignored.
  - start with cfg_in_ch=0 or cfg_out_ch=0: done pulses the next cycle, busy stays low, and there is no engine or RAM activity.
- Timeout: if WAIT_RES lasts TIMEOUT cycles, set err, assert eng_clear for 1 cycle, go to FIN (done pulses), and emit nothing further.

## Timing

- Reset values: every output is 0 and the state is IDLE. eng_num_out_ch is 1; all other outputs are zero.
- Reset mid-layer aborts on the next edge. No done pulse is produced and out_valid drops immediately.
- Per-batch cadence is exactly 4 cycles (FETCH, LOAD, GAP1, GAP2). eng_load pulses are therefore spaced by 3 idle cycles.
- RAM data is sampled in LOAD, the cycle after FETCH.
- Per output channel: 1 + 4*nb + engine latency + cycles stalled in EMIT.
- out_valid, out_data and out_ch are held stable while out_ready=0. There is at most one outstanding result.
- busy rises the cycle after start and falls in the same cycle that done pulses.

## Configuration

- PW_SEQ_RELU_EN defined: out_data = (eng_result < 0) ? 0 : eng_result.
- PW_SEQ_RELU_EN undefined: out_data is the raw signed eng_result.

## Test plan

- Ones in both RAMs, cfg_in_ch=96, cfg_out_ch=1: 6 eng_load pulses spaced 4 cycles apart, wt_rd_addr 0..5, then out_data=96, out_ch=0, then done.
- cfg_in_ch=20, cfg_out_ch=2, ones in both RAMs: lanes 4..15 of the second load are zero, and out_data=20 for both channels. Channel 1 must read wt_rd_addr 2..3.
- out_ready held low for 5 cycles during EMIT: out_valid, out_data and out_ch stay stable, and the next eng_start appears only after the handshake.
- start pulsed while busy: no effect on counters or addresses. start with cfg_out_ch=0: done pulses 1 cycle later and busy never rises.
- eng_result_valid suppressed with TIMEOUT=16: err=1 after 16 cycles in WAIT_RES, one eng_clear pulse, done pulses, and out_valid never asserts.
- Reset during batch 3 of channel 0: all outputs are 0 the next cycle; a following start with cfg_in_ch=16, cfg_out_ch=1 completes normally with no err.
- With PW_SEQ_RELU_EN defined, weights of -1 (0xFF) and activations of 1: out_data=0. Without the macro: out_data=-cfg_in_ch.
